condlogic_it: RTL
=================

# condlogic_it

Parametrised execute-stage condition unit for the pipelined ARM core, successor to the basic condition logic. It holds the NZCV flag register with configurable flag-write granularity, evaluates the 4-bit ARM condition field, and gates register, memory, PC and branch writes. It also contains a Thumb-2-style IT-block sequencer that supplies derived conditions for up to ITMAX following instructions. Valid and stall qualifiers come from the hazard unit.

## Interface
- ITMAX, 4: maximum IT-block length, range 1..4.
- NGRP, 2: flag-write groups.
  - 2 means {N,Z} and {C,V}.
  - 4 means one enable per flag.
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- ValidE  in  1  execute stage holds a real instruction
- StallE  in  1  execute stage held; no state advances
- FlushE  in  1  cancel any active IT block
- Cond  in  4  instruction condition field (used outside IT blocks)
- ALUFlags  in  4  {N,Z,C,V} from ALU
- FlagW  in  NGRP  flag group write requests; bit NGRP-1 is the most significant group
- PCS, RegW, MemW, BranchE  in  1 each  unconditional write requests
- ITStart  in  1  current instruction is an IT instruction
- ITCond  in  4  IT base condition
- ITMask  in  ITMAX  per-slot then(1)/else(0), slot 0 = bit 0
- ITLen  in  3  number of slots
- PCSrc, RegWrite, MemWrite, BranchTakenE  out  1 each  gated requests
- CondEx  out  1  effective condition passed and ValidE
- Flags  out  4  registered {N,Z,C,V}
- InIT  out  1  sequencer in ACTIVE state

## Operation
- Condition codes 0000–1110 follow ARM semantics: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL.
  - HI = C & ~Z.
  - GE = (N==V).
  - GT = ~Z & GE.
- Code 1111 is reserved and evaluates to 0. It must never produce X.
- Effective condition source:
  - In IDLE: Cond.
  - In ACTIVE, slot k: {ITCond[3:1], ITCond[0] ^ ~ITMask[k]}.
  - If the latched ITCond==1110, every slot uses 1110; mask bits are ignored.
- CondEx = ValidE & pass(effective condition, Flags).
- RegWrite, MemWrite, PCSrc, BranchTakenE each equal the matching request ANDed with CondEx.
- An instruction with ITStart=1 in IDLE drives all four gated outputs to 0.
- Let Adv = ValidE & ~StallE.
- Flag writes:
  - Group g is written when Adv & CondEx & FlagW[g].
  - A failed-condition instruction never writes flags.
- Sequencer states: IDLE, ACTIVE. It holds ITCond, ITMask, a remaining count and a slot index.
  - IDLE → ACTIVE: Adv & ITStart & ~FlushE & ITLen≠0.
    - Latch ITCond and ITMask.
    - remaining = min(ITLen, ITMAX); slot = 0.
  - ITLen=0 leaves the sequencer in IDLE.
  - ACTIVE, Adv: slot+1, remaining−1. When remaining reaches 0, go to IDLE.
    - A slot whose condition fails still consumes the slot.
  - ITStart while ACTIVE is ignored. That instruction is treated as an ordinary slot instruction.
  - FlushE, any state: go to IDLE on the next edge. FlushE has priority over Adv and ITStart.
- Flags update and sequencer update happen on the same edge. A slot-k instruction that writes flags affects slot k+1.

## Timing
- CondEx and the gated outputs are combinational from inputs and registered state. There is no added latency.
- Flags and InIT change only on the rising edge after the qualifying cycle.
- StallE=1 freezes Flags and all sequencer registers. Combinational outputs still reflect the held inputs.
- Reset values:
  - Flags = 0000.
  - State = IDLE, InIT = 0, slot/remaining = 0.
  - Gated outputs follow from Flags = 0 (e.g. Cond=0001 passes).
- Reset asserted mid-block aborts the block immediately and asynchronously.

## Structure
- Package condlogic_pkg holds:
  - the cond_e enum of the 16 codes;
  - flag index constants N=3, Z=2, C=1, V=0;
  - the it_state_e enum {IDLE, ACTIVE}.
- Sub-module cond_eval is purely combinational: (cond, flags) → pass. Instantiate it once on the effective condition.
- Flag register: one enable flop bank per group, width 4/NGRP.

## Test plan
- Reset, then ALUFlags=0100, FlagW=11, Cond=1110, ValidE=1 → Flags=0100 next cycle. Following Cond=0000 with RegW=1 → CondEx=1, RegWrite=1.
- NGRP=2, Flags=0000, ALUFlags=1111, FlagW=10 → Flags=1100. With NGRP=4, FlagW=0010 → Flags=0010.
- Z=1, ITStart with ITCond=0000, ITMask=0101, ITLen=3 → three slots give CondEx 1,0,1 regardless of Cond. InIT falls after slot 2. The fourth instruction uses Cond.
- Active block, StallE=1 for 2 cycles at slot 1 with FlagW=11 → slot index and Flags unchanged. Slot 1 completes after stall release.
- FlushE at slot 0 → IDLE next edge. FlushE together with ITStart in IDLE → stays IDLE. ITLen=7 with ITMAX=4 → 4 slots.
- Cond=1111 → CondEx=0. A failed-condition instruction with FlagW=11 → Flags unchanged. Reset pulse mid-block → InIT=0 and Flags=0000 immediately.

Source files
------------

// File: rtl/condlogic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : condlogic_pkg
// Purpose  : Shared types and constants for the execute-stage condition unit:
//            ARM condition codes, NZCV bit positions, and IT sequencer states.
// Revision : 1.0  initial release
// ============================================================================
package condlogic_pkg;

    // ARM condition field encodings; NV (1111) is reserved and never passes.
    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_e;

    // Bit positions inside the {N,Z,C,V} flag vector.
    localparam int N = 3;
    localparam int Z = 2;
    localparam int C = 1;
    localparam int V = 0;

    // IT-block sequencer states.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } it_state_e;

endpackage : condlogic_pkg
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : cond_eval
// Purpose  : Purely combinational ARM condition check.
// Ports    : i_cond  [3:0] condition field
//            i_flags [3:0] {N,Z,C,V}
//            o_pass        1 when the condition holds (reserved code -> 0)
// Revision : 1.0  initial release
// ============================================================================
module cond_eval
    import condlogic_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass
);

    logic w_n, w_z, w_c, w_v, w_ge;

    assign w_n  = i_flags[N];
    assign w_z  = i_flags[Z];
    assign w_c  = i_flags[C];
    assign w_v  = i_flags[V];
    assign w_ge = (w_n == w_v);

    always_comb begin
        o_pass = 1'b0;
        case (cond_e'(i_cond))
            EQ: o_pass = w_z;
            NE: o_pass = ~w_z;
            CS: o_pass = w_c;
            CC: o_pass = ~w_c;
            MI: o_pass = w_n;
            PL: o_pass = ~w_n;
            VS: o_pass = w_v;
            VC: o_pass = ~w_v;
            HI: o_pass = w_c & ~w_z;
            LS: o_pass = ~(w_c & ~w_z);
            GE: o_pass = w_ge;
            LT: o_pass = ~w_ge;
            GT: o_pass = ~w_z & w_ge;
            LE: o_pass = ~(~w_z & w_ge);
            AL: o_pass = 1'b1;
            default: o_pass = 1'b0;  // NV: reserved, forced low so it never propagates X
        endcase
    end

endmodule : cond_eval
`default_nettype wire

// File: rtl/condlogic_it.sv
`default_nettype none
// ============================================================================
// Module   : condlogic_it
// Purpose  : Execute-stage condition unit with NZCV flag register (grouped
//            write enables), condition evaluation, write gating and a
//            Thumb-2-style IT-block sequencer.
// Ports    : clk, reset (async, active-high)
//            ValidE/StallE/FlushE    hazard-unit qualifiers
//            Cond, ALUFlags, FlagW   condition field, new flags, group writes
//            PCS/RegW/MemW/BranchE   unconditional write requests
//            ITStart/ITCond/ITMask/ITLen  IT instruction fields
//            PCSrc/RegWrite/MemWrite/BranchTakenE  gated requests
//            CondEx, Flags, InIT     condition result, flag register, IT active
// Revision : 1.0  initial release
// ============================================================================
module condlogic_it
    import condlogic_pkg::*;
#(
    parameter int ITMAX = 4,
    parameter int NGRP  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidE,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [NGRP-1:0]  FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             BranchE,
    input  logic             ITStart,
    input  logic [3:0]       ITCond,
    input  logic [ITMAX-1:0] ITMask,
    input  logic [2:0]       ITLen,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             BranchTakenE,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic             InIT
);

    localparam int        GW          = 4 / NGRP;
    localparam logic [2:0] c_ITMAX_L  = 3'(ITMAX);

    it_state_e        r_state;
    logic [3:0]       r_cond;
    logic [ITMAX-1:0] r_mask;
    logic [2:0]       r_rem;
    logic [2:0]       r_slot;

    logic [3:0]       w_flags;
    logic             w_mask_bit;
    logic [3:0]       w_eff_cond;
    logic             w_pass;
    logic             w_condex;
    logic             w_it_issue;
    logic             w_gate;
    logic             w_adv;
    logic [2:0]       w_len_clip;

    // ------------------------------------------------------------------
    // Effective condition selection
    // ------------------------------------------------------------------
    always_comb begin
        w_mask_bit = 1'b0;
        for (int k = 0; k < ITMAX; k++) begin
            if (r_slot == 3'(k)) begin
                w_mask_bit = r_mask[k];
            end
        end
    end

    // Inside a block the low bit of the base condition is flipped for
    // "else" slots; an AL base is never inverted (would become reserved NV).
    always_comb begin
        w_eff_cond = Cond;
        if (r_state == ACTIVE) begin
            if (r_cond == 4'b1110) begin
                w_eff_cond = 4'b1110;
            end else begin
                w_eff_cond = {r_cond[3:1], r_cond[0] ^ ~w_mask_bit};
            end
        end
    end

    cond_eval u_cond_eval (
        .i_cond  (w_eff_cond),
        .i_flags (w_flags),
        .o_pass  (w_pass)
    );

    assign w_condex   = ValidE & w_pass;
    // The IT instruction itself performs no architectural writes.
    assign w_it_issue = ITStart & (r_state == IDLE);
    assign w_gate     = w_condex & ~w_it_issue;
    assign w_adv      = ValidE & ~StallE;
    assign w_len_clip = (ITLen > c_ITMAX_L) ? c_ITMAX_L : ITLen;

    assign CondEx       = w_condex;
    assign PCSrc        = PCS     & w_gate;
    assign RegWrite     = RegW    & w_gate;
    assign MemWrite     = MemW    & w_gate;
    assign BranchTakenE = BranchE & w_gate;
    assign Flags        = w_flags;
    assign InIT         = (r_state == ACTIVE);

    // ------------------------------------------------------------------
    // Flag register: one independently enabled bank per write group
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        logic [GW-1:0] r_grp;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_grp <= '0;
            end else if (w_adv & w_condex & FlagW[g]) begin
                r_grp <= ALUFlags[g*GW +: GW];
            end
        end

        assign w_flags[g*GW +: GW] = r_grp;
    end

    // ------------------------------------------------------------------
    // IT sequencer. Flush overrides everything, including a stall, so a
    // cancelled block can never leak conditions into later instructions.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cond  <= 4'b0000;
            r_mask  <= '0;
            r_rem   <= 3'd0;
            r_slot  <= 3'd0;
        end else if (FlushE) begin
            r_state <= IDLE;
            r_rem   <= 3'd0;
            r_slot  <= 3'd0;
        end else if (w_adv) begin
            case (r_state)
                IDLE: begin
                    if (ITStart && (ITLen != 3'd0)) begin
                        r_state <= ACTIVE;
                        r_cond  <= ITCond;
                        r_mask  <= ITMask;
                        r_rem   <= w_len_clip;
                        r_slot  <= 3'd0;
                    end
                end
                ACTIVE: begin
                    // Every advancing instruction consumes a slot, pass or fail.
                    if (r_rem <= 3'd1) begin
                        r_state <= IDLE;
                        r_rem   <= 3'd0;
                        r_slot  <= 3'd0;
                    end else begin
                        r_rem   <= r_rem - 3'd1;
                        r_slot  <= r_slot + 3'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : condlogic_it
`default_nettype wire
